fc_rx_primitive_decoder: RTL



---
 rtl/fc_rx_primitive_decoder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fc_rx_primitive_decoder.sv
// rtl/fc_rx_primitive_decoder.sv - FC rx word classifier, link-state tracker and frame delimiter
// Single register stage from xcvr word to Avalon-ST frame stream and counters.
module fc_rx_primitive_decoder #(
    parameter int CNT_W   = 16,
    parameter int SEQ_RUN = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      rx_data,
    input  logic [3:0]       rx_datak,
    input  logic [3:0]       rx_errdetect,
    input  logic [3:0]       rx_disperr,
    input  logic [3:0]       rx_syncstatus,
    output logic [31:0]      out_data,
    output logic             out_valid,
    output logic             out_startofpacket,
    output logic             out_endofpacket,
    output logic             out_error,
    output logic [2:0]       link_state,
    output logic [CNT_W-1:0] r_rdy_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int RUN_W = $clog2(SEQ_RUN + 1);

    typedef enum logic [2:0] {
        LS_ACTIVE  = 3'd0,
        LS_LR      = 3'd1,
        LS_LRR     = 3'd2,
        LS_NOS     = 3'd3,
        LS_OLS     = 3'd4,
        LS_NOSYNC  = 3'd5,
        LS_UNKNOWN = 3'd6
    } link_t;

    typedef enum logic [2:0] {
        PC_NONE, PC_ACT, PC_NOS, PC_OLS, PC_LR, PC_LRR
    } prim_t;

    logic [7:0] b0, b1, b2, b3;
    assign b0 = rx_data[7:0];
    assign b1 = rx_data[15:8];
    assign b2 = rx_data[23:16];
    assign b3 = rx_data[31:24];

    logic is_os, is_idle, is_rrdy, is_sof, is_eof, is_eofa;
    logic is_nos, is_ols, is_lr, is_lrr, is_data, other_k, word_err, sync_ok;

    always_comb begin
        is_os   = (rx_datak == 4'b0001) && (b0 == 8'hBC);
        is_idle = is_os && b1 == 8'h95 && b2 == 8'hB5 && b3 == 8'hB5;
        is_rrdy = is_os && b1 == 8'h95 && b2 == 8'h4A && b3 == 8'h4A;
        is_sof  = 1'b0;
        if (is_os && b1 == 8'hB5 && b2 == b3) begin
            case (b2)
                8'h57, 8'h37, 8'h55, 8'h35, 8'h56, 8'h36, 8'h58: is_sof = 1'b1;
                default:                                         is_sof = 1'b0;
            endcase
        end
        is_eof  = is_os && (b1 == 8'h95 || b1 == 8'hB5) && b2 == b3 &&
                  (b2 == 8'h75 || b2 == 8'hD5 || b2 == 8'hF5);
        is_eofa = is_eof && b2 == 8'hF5;
        is_nos  = is_os && b1 == 8'h55 && b2 == 8'hBF && b3 == 8'h45;
        is_ols  = is_os && b1 == 8'h35 && b2 == 8'h8A && b3 == 8'h55;
        is_lr   = is_os && b1 == 8'h49 && b2 == 8'hBF && b3 == 8'h49;
        is_lrr  = is_os && b1 == 8'h35 && b2 == 8'hBF && b3 == 8'h49;
        is_data = (rx_datak == 4'b0000);
        other_k = !is_data && !(is_idle || is_rrdy || is_sof || is_eof ||
                                is_nos || is_ols || is_lr || is_lrr);
        word_err = (|rx_errdetect) || (|rx_disperr);
        sync_ok  = (rx_syncstatus == 4'hF);
    end

    logic [31:0]      out_data_q, out_data_d;
    logic             valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
    logic             in_frame_q, in_frame_d, sticky_q, sticky_d;
    logic             frame_inc;
    link_t            link_q, link_d;
    prim_t            last_q, last_d, pc;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] r_rdy_cnt_q, frame_cnt_q, err_cnt_q;

    // Frame path: sync loss or a stray ordered set inside a frame aborts it.
    always_comb begin
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        in_frame_d = in_frame_q;
        sticky_d   = sticky_q;
        frame_inc  = 1'b0;
        if (!sync_ok) begin
            if (in_frame_q) begin
                valid_d    = 1'b1;
                eop_d      = 1'b1;
                err_d      = 1'b1;
                in_frame_d = 1'b0;
            end
        end else if (is_sof) begin
            valid_d    = 1'b1;
            sop_d      = 1'b1;
            in_frame_d = 1'b1;
            sticky_d   = word_err;
        end else if (in_frame_q) begin
            valid_d = 1'b1;
            if (is_data || other_k) begin
                sticky_d = sticky_q | word_err | other_k;
            end else if (is_eof) begin
                eop_d      = 1'b1;
                err_d      = is_eofa | sticky_q | word_err;
                in_frame_d = 1'b0;
                frame_inc  = !(is_eofa | sticky_q | word_err);
            end else begin
                eop_d      = 1'b1;
                err_d      = 1'b1;
                in_frame_d = 1'b0;
            end
        end
        out_data_d = valid_d ? rx_data : out_data_q;
    end

    // Link state: a run of SEQ_RUN identical primitive classes commits the state.
    always_comb begin
        pc = PC_NONE;
        if (is_nos)                                            pc = PC_NOS;
        else if (is_ols)                                       pc = PC_OLS;
        else if (is_lr)                                        pc = PC_LR;
        else if (is_lrr)                                       pc = PC_LRR;
        else if (is_idle || is_rrdy || is_sof || is_eof || is_data) pc = PC_ACT;

        link_d = link_q;
        last_d = last_q;
        run_d  = run_q;
        if (!sync_ok) begin
            link_d = LS_NOSYNC;
            last_d = PC_NONE;
            run_d  = '0;
        end else if (pc == PC_NONE) begin
            last_d = PC_NONE;
            run_d  = '0;
        end else begin
            if (pc == last_q)
                run_d = (run_q >= RUN_W'(SEQ_RUN)) ? run_q : run_q + 1'b1;
            else
                run_d = RUN_W'(1);
            last_d = pc;
            if (run_d >= RUN_W'(SEQ_RUN)) begin
                case (pc)
                    PC_NOS:  link_d = LS_NOS;
                    PC_OLS:  link_d = LS_OLS;
                    PC_LR:   link_d = LS_LR;
                    PC_LRR:  link_d = LS_LRR;
                    PC_ACT:  link_d = LS_ACTIVE;
                    default: link_d = LS_UNKNOWN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
            in_frame_q  <= 1'b0;
            sticky_q    <= 1'b0;
            link_q      <= LS_NOSYNC;
            last_q      <= PC_NONE;
            run_q       <= '0;
            r_rdy_cnt_q <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            out_data_q <= out_data_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
            in_frame_q <= in_frame_d;
            sticky_q   <= sticky_d;
            link_q     <= link_d;
            last_q     <= last_d;
            run_q      <= run_d;
            if (is_rrdy)
                r_rdy_cnt_q <= r_rdy_cnt_q + 1'b1;
            if (frame_inc)
                frame_cnt_q <= frame_cnt_q + 1'b1;
            if (word_err && link_q != LS_NOSYNC)
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign out_data          = out_data_q;
    assign out_valid         = valid_q;
    assign out_startofpacket = sop_q;
    assign out_endofpacket   = eop_q;
    assign out_error         = err_q;
    assign link_state        = link_q;
    assign r_rdy_cnt         = r_rdy_cnt_q;
    assign frame_cnt         = frame_cnt_q;
    assign err_cnt           = err_cnt_q;
endmodule
